alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 4-bit combinational ALU. Registers operands on accept,

---
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier, with results held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             l,
    output logic             c,
    output logic             v
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               accept;
    logic               start_mul;
    logic               mul_last;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               hi_q, hi_d;

    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH-1:0]   alu_res;
    logic [3:0]         alu_flags;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [SHW-1:0]     shamt;
    logic signed [WIDTH-1:0] a_s, b_s;

    function automatic logic is_mul_op(input logic [3:0] f);
        return MUL_EN && ((f == 4'd12) || (f == 4'd13));
    endfunction

    assign a_s       = a;
    assign b_s       = b;
    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = a - b;
    assign shamt     = b[SHW-1:0];
    assign accept    = in_valid & in_ready;
    assign start_mul = is_mul_op(func);
    assign mul_last  = (state_q == S_MUL) && (cnt_q == SHW'(WIDTH - 1));

    // Single-cycle ALU; flags packed as {z, l, c, v}
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (func)
            4'd0: begin
                alu_res      = sum[WIDTH-1:0];
                alu_flags[1] = sum[WIDTH];
                alu_flags[0] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                alu_res      = diff;
                alu_flags[1] = (a < b);
                alu_flags[0] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:  alu_res = ~a;
            4'd3:  alu_res = a & b;
            4'd4:  alu_res = a | b;
            4'd5:  alu_res = a ^ b;
            4'd6:  alu_flags[2] = (a < b);
            4'd7:  alu_flags[3] = (a == b);
            4'd8:  alu_flags[2] = (a_s < b_s);
            4'd9:  alu_res = a << shamt;
            4'd10: alu_res = a >> shamt;
            4'd11: alu_res = a_s >>> shamt;
            default: ;
        endcase
    end

    // Datapath next-state: operand capture, multiplier iteration, result load
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        result_d = result_q;
        flags_d  = flags_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (accept) begin
            if (start_mul) begin
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                cnt_d    = '0;
                hi_d     = func[0];
            end else begin
                result_d = alu_res;
                flags_d  = alu_flags;
            end
        end else if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (mul_last) begin
                result_d = hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
                flags_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            hi_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = start_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (mul_last) state_d = S_DONE;
            end
            S_DONE: begin
                if (accept)         state_d = start_mul ? S_MUL : S_DONE;
                else if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // DONE with a consumer ready can take the next op in the same cycle
    always_comb begin
        in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
        out_valid = (state_q == S_DONE);
    end

    assign result = result_q;
    assign z      = flags_q[3];
    assign l      = flags_q[2];
    assign c      = flags_q[1];
    assign v      = flags_q[0];

endmodule

// File: tb/tb_alu_seq.sv
// Randomized scoreboard bench for alu_seq at WIDTH=8 with an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   func = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         z, l, c, v;

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .l         (l),
        .c         (c),
        .v         (v)
    );

    typedef struct {
        logic [W+3:0] val;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mode = 2;
    bit   fresh = 1'b1;
    int   last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic, result reduced modulo 2^W
    function automatic logic [W+3:0] model(input logic [3:0] f, input logic [W-1:0] ai, input logic [W-1:0] bi);
        longint m    = longint'(1) << W;
        longint half = m / 2;
        longint ua   = longint'(ai);
        longint ub   = longint'(bi);
        longint sa, sb, r;
        bit     zz = 0, ll = 0, cc = 0, vv = 0;
        int     sh;
        sa = (ua >= half) ? ua - m : ua;
        sb = (ub >= half) ? ub - m : ub;
        sh = int'(ub % W);
        r  = 0;
        case (f)
            4'd0: begin r = ua + ub; cc = (r >= m); vv = ((sa + sb) >= half) || ((sa + sb) < -half); end
            4'd1: begin r = ua - ub; cc = (ua < ub); vv = ((sa - sb) >= half) || ((sa - sb) < -half); end
            4'd2: r = m - 1 - ua;
            4'd3: r = ua & ub;
            4'd4: r = ua | ub;
            4'd5: r = ua ^ ub;
            4'd6: ll = (ua < ub);
            4'd7: zz = (ua == ub);
            4'd8: ll = (sa < sb);
            4'd9: r = ua * (longint'(1) << sh);
            4'd10: r = ua / (longint'(1) << sh);
            4'd11: r = sa >>> sh;
            4'd12: r = ua * ub;
            4'd13: r = (ua * ub) / m;
            default: r = 0;
        endcase
        r = ((r % m) + m) % m;
        return {W'(r), zz, ll, cc, vv};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    task automatic send(input logic [3:0] f, input logic [W-1:0] ai, input logic [W-1:0] bi);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        func = f;
        a = ai;
        b = bi;
        in_valid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                e.val     = model(f, ai, bi);
                e.lat     = (f == 4'd12 || f == 4'd13) ? W : 0;
                e.acc_cyc = cyc + 1;
                last_acc  = e.acc_cyc;
                sbq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout func=%0d in_ready=%0b required=1", f, in_ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        mode = 2;
        out_ready = 1'b1;
        while (sbq.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (mode == 0) out_ready = 1'($urandom_range(0, 1));
        else           out_ready = (mode == 2);
    end

    // Monitor: compares the head expectation whenever a result is presented
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got=%0h required=none", {result, z, l, c, v});
            end else begin
                if ({result, z, l, c, v} !== sbq[0].val) begin
                    errors++;
                    $display("FAIL result_flags got=%0h required=%0h", {result, z, l, c, v}, sbq[0].val);
                end
                if (fresh) begin
                    checks++;
                    if (cyc != sbq[0].acc_cyc + sbq[0].lat) begin
                        errors++;
                        $display("FAIL latency got=%0d required=%0d", cyc - sbq[0].acc_cyc, sbq[0].lat);
                    end
                    fresh = 1'b0;
                end
                if (out_ready) begin
                    void'(sbq.pop_front());
                    fresh = 1'b1;
                end
            end
        end
    end

    initial begin
        int acc_prev;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_result_flags", 64'({result, z, l, c, v}), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        mode = 2;
        out_ready = 1'b1;
        send(4'd0, 8'h90, 8'h80);
        send(4'd1, 8'h03, 8'h05);
        send(4'd6, 8'h03, 8'h05);
        send(4'd8, 8'h03, 8'hFD);
        send(4'd7, 8'h06, 8'h06);
        send(4'd11, 8'h80, 8'h0B);
        send(4'd9, 8'h81, 8'h02);
        send(4'd10, 8'h81, 8'h0F);
        send(4'd2, 8'h3C, 8'h00);
        send(4'd15, 8'hAA, 8'h55);
        send(4'd14, 8'hFF, 8'hFF);
        drain();

        send(4'd12, 8'hFF, 8'h02);
        repeat (W) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            chk("mul_busy_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        send(4'd13, 8'hFF, 8'h02);
        repeat (W) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            chk("mulhu_busy_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        drain();

        mode = 1;
        out_ready = 1'b0;
        send(4'd0, W'($urandom), W'($urandom));
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        mode = 2;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc_prev = last_acc;
            send(4'd5, W'($urandom), W'($urandom));
            if (i > 0) chk("stream_spacing", 64'(last_acc - acc_prev), 64'd1);
        end
        drain();

        send(4'd12, W'($urandom), W'($urandom));
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        sbq.delete();
        fresh = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result_flags", 64'({result, z, l, c, v}), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send(4'd0, 8'h02, 8'h02);
        drain();

        mode = 0;
        repeat (150) send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
